// File: rtl/clken_nco_bank.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per
// channel, carry-out registered as a one-cycle enable, gated by a relock model.
module clken_nco_bank #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = '0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              phase_align,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] pend,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_CYCLES);

  logic [ACC_W-1:0]  acc      [NUM_CH];
  logic [ACC_W-1:0]  inc      [NUM_CH];
  logic [ACC_W-1:0]  pend_inc [NUM_CH];
  logic [ACC_W:0]    sum      [NUM_CH];
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] wr_hit;
  logic              wr_ok;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_nxt;

  always_comb begin
    wr_ok    = cfg_we && (int'(cfg_ch) < NUM_CH);
    lock_nxt = lock_cnt + 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
      wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
      // While running, swap increments only on a carry so the old period
      // completes; a stalled (inc=0) channel would never carry, so take it now.
      apply[i]  = pend[i] && (!locked || sum[i][ACC_W] || (inc[i] == '0));
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i]      <= '0;
        inc[i]      <= INIT_INC[i*ACC_W +: ACC_W];
        pend_inc[i] <= '0;
      end
      ce       <= '0;
      pend     <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!locked || phase_align) begin
          acc[i] <= '0;
          ce[i]  <= 1'b0;
        end else begin
          acc[i] <= sum[i][ACC_W-1:0];
          ce[i]  <= sum[i][ACC_W];
        end
        if (apply[i]) inc[i] <= pend_inc[i];
        if (wr_hit[i]) begin
          pend[i]     <= 1'b1;
          pend_inc[i] <= cfg_inc;
        end else if (apply[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (wr_ok) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (!locked) begin
        lock_cnt <= lock_nxt;
        locked   <= (lock_nxt == LOCK_VAL);
      end
    end
  end

endmodule
